// File: rtl/key_debounce_10ms.sv
// Key debouncer paced by a 10 ms tick: 2-FF synchronizers, 4-state debounce FSM, press/release pulses.
// Optional auto-repeat while held is compiled in with `define KEY_REPEAT_EN.
module key_debounce_10ms #(
  parameter int unsigned STABLE_TICKS = 3,
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_10ms,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam logic [1:0] StIdle        = 2'd0;
  localparam logic [1:0] StPressWait   = 2'd1;
  localparam logic [1:0] StPressed     = 2'd2;
  localparam logic [1:0] StReleaseWait = 2'd3;

  // Out-of-range parameters are clamped to the legal counter ranges.
  localparam logic [3:0] StableLim =
      (STABLE_TICKS < 1) ? 4'd1 : (STABLE_TICKS > 15) ? 4'd15 : 4'(STABLE_TICKS);
  localparam logic [7:0] HoldLim =
      (HOLD_TICKS < 1) ? 8'd1 : (HOLD_TICKS > 255) ? 8'd255 : 8'(HOLD_TICKS);
  localparam logic [7:0] RepLim =
      (REPEAT_TICKS < 1) ? 8'd1 : (REPEAT_TICKS > 255) ? 8'd255 : 8'(REPEAT_TICKS);

  logic       key_meta_q, key_sync_q;
  logic       clk_meta_q, clk_sync_q, clk_prev_q;
  logic       tick;

  logic [1:0] state_q, state_d;
  logic [3:0] stable_cnt_q, stable_cnt_d;
  logic [3:0] stable_inc;
  logic       key_level_q, key_level_d;
  logic       key_press_q, key_press_d;
  logic       key_release_q, key_release_d;
  logic       press_evt;

  assign tick       = clk_sync_q & ~clk_prev_q;
  assign stable_inc = (stable_cnt_q == 4'hF) ? stable_cnt_q : stable_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
      clk_meta_q <= 1'b0;
      clk_sync_q <= 1'b0;
      clk_prev_q <= 1'b0;
    end else begin
      key_meta_q <= key_in;
      key_sync_q <= key_meta_q;
      clk_meta_q <= clk_10ms;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
    end
  end

  // Debounce FSM; everything holds between ticks so pulses drop to 0 by default.
  always_comb begin
    state_d       = state_q;
    stable_cnt_d  = stable_cnt_q;
    key_level_d   = key_level_q;
    press_evt     = 1'b0;
    key_release_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (key_sync_q) begin
            if (StableLim == 4'd1) begin
              state_d      = StPressed;
              stable_cnt_d = 4'd0;
              key_level_d  = 1'b1;
              press_evt    = 1'b1;
            end else begin
              state_d      = StPressWait;
              stable_cnt_d = 4'd1;
            end
          end
        end
        StPressWait: begin
          if (key_sync_q) begin
            if (stable_inc >= StableLim) begin
              state_d      = StPressed;
              stable_cnt_d = 4'd0;
              key_level_d  = 1'b1;
              press_evt    = 1'b1;
            end else begin
              stable_cnt_d = stable_inc;
            end
          end else begin
            state_d      = StIdle;
            stable_cnt_d = 4'd0;
          end
        end
        StPressed: begin
          if (!key_sync_q) begin
            if (StableLim == 4'd1) begin
              state_d       = StIdle;
              stable_cnt_d  = 4'd0;
              key_level_d   = 1'b0;
              key_release_d = 1'b1;
            end else begin
              state_d      = StReleaseWait;
              stable_cnt_d = 4'd1;
            end
          end
        end
        StReleaseWait: begin
          if (!key_sync_q) begin
            if (stable_inc >= StableLim) begin
              state_d       = StIdle;
              stable_cnt_d  = 4'd0;
              key_level_d   = 1'b0;
              key_release_d = 1'b1;
            end else begin
              stable_cnt_d = stable_inc;
            end
          end else begin
            // Bounce back to pressed: no new press pulse, hold timing continues.
            state_d      = StPressed;
            stable_cnt_d = 4'd0;
          end
        end
        default: begin
          state_d      = StIdle;
          stable_cnt_d = 4'd0;
          key_level_d  = 1'b0;
        end
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] hold_inc;
  logic       repeating_q, repeating_d;
  logic       repeat_evt;

  assign hold_inc = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;

  // One counter serves both the initial hold delay and the repeat interval.
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    repeating_d = repeating_q;
    repeat_evt  = 1'b0;
    if ((state_q == StIdle) || (state_q == StPressWait)) begin
      hold_cnt_d  = 8'd0;
      repeating_d = 1'b0;
    end else if (tick && (state_d != StIdle)) begin
      if (!repeating_q) begin
        if (hold_inc >= HoldLim) begin
          hold_cnt_d  = 8'd0;
          repeating_d = 1'b1;
          repeat_evt  = 1'b1;
        end else begin
          hold_cnt_d = hold_inc;
        end
      end else begin
        if (hold_inc >= RepLim) begin
          hold_cnt_d = 8'd0;
          repeat_evt = 1'b1;
        end else begin
          hold_cnt_d = hold_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q  <= 8'd0;
      repeating_q <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      repeating_q <= repeating_d;
    end
  end

  assign key_press_d = (press_evt | repeat_evt) & ~key_release_d;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{HoldLim, RepLim};
  assign key_press_d = press_evt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      stable_cnt_q  <= 4'd0;
      key_level_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stable_cnt_q  <= stable_cnt_d;
      key_level_q   <= key_level_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  assign key_level   = key_level_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule

// File: doc/key_debounce_10ms.md
KEY_DEBOUNCE_10MS -- requirements
Module: key_debounce_10ms

Interface
REQ-001 STABLE_TICKS, default 3: consecutive equal ticks needed to accept a key level change (range 1-15).
REQ-002 HOLD_TICKS, default 50: ticks a key must stay pressed before auto-repeat begins (range 1-255).
REQ-003 REPEAT_TICKS, default 10: ticks between auto-repeat pulses (range 1-255).
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clk_10ms  input  1  slow square wave from the 10 ms divider; asynchronous to clk.
REQ-007 key_in  input  1  raw mechanical key, active-high, asynchronous, bouncing.
REQ-008 key_level  output  1  debounced key state, registered.
REQ-009 key_press  output  1  one-clk pulse on accepted press, and on each repeat when enabled.
REQ-010 key_release  output  1  one-clk pulse on accepted release.

Function
REQ-011 key_in and clk_10ms each pass through a 2-FF synchronizer before use.
REQ-012 tick = one-clk pulse on the rising edge of synchronized clk_10ms; all counting advances only on tick.
REQ-013 FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 IDLE: on tick with synced key=1 -> PRESS_WAIT, stable count=1; if STABLE_TICKS=1, go directly to PRESSED.
REQ-015 PRESS_WAIT: tick with key=1 increments count; count reaching STABLE_TICKS -> PRESSED; tick with key=0 -> IDLE, count cleared.
REQ-016 Entering PRESSED: key_level=1 and key_press=1 for exactly the clk cycle after the qualifying tick.
REQ-017 PRESSED: tick with key=0 -> RELEASE_WAIT, count=1; key_level stays 1.
REQ-018 RELEASE_WAIT: tick with key=0 increments count; reaching STABLE_TICKS -> IDLE, key_level=0, key_release one-clk pulse; tick with key=1 -> PRESSED, no press pulse, hold counter preserved.
REQ-019 Key changes between ticks are ignored; only the synced value at each tick counts.
REQ-020 key_press and key_release are never asserted in the same cycle.
REQ-021 Counters saturate; no wrap-around.
REQ-022 clk_10ms held constant: FSM and outputs freeze, pulses deassert.

Reset
REQ-023 rst=1 at a clk edge: FSM=IDLE, all counters=0, synchronizers=0, key_level=0, key_press=0, key_release=0.
REQ-024 rst mid-debounce or mid-hold discards progress with no release pulse; operation resumes on the first tick after rst drops.

Configuration
REQ-025 Macro KEY_REPEAT_EN selects auto-repeat.
REQ-026 KEY_REPEAT_EN defined: a hold counter runs in PRESSED/RELEASE_WAIT; after HOLD_TICKS ticks it emits a key_press pulse, then one every REPEAT_TICKS ticks until release is accepted.
REQ-027 KEY_REPEAT_EN undefined: no hold or repeat logic; exactly one key_press per accepted press.

Verification
REQ-028 Clean press: key_in=1 held, STABLE_TICKS=3 -> key_press one cycle after the 3rd tick, key_level=1.
REQ-029 Bounce: key_in 1 for 2 ticks, 0 at 3rd, then 1 for 3 ticks -> single key_press after tick 6.
REQ-030 Release: pressed key goes 0 for 3 ticks -> key_release one cycle after 3rd tick, key_level=0; glitch 0-1 inside window -> no release.
REQ-031 Reset: rst asserted while in PRESSED -> next cycle key_level=0, no key_release pulse.
REQ-032 Repeat (KEY_REPEAT_EN, HOLD=50, REPEAT=10): key held 80 ticks -> press at tick 3, repeats at ticks 53, 63, 73; none without macro.
REQ-033 Frozen clk_10ms: key_in toggled for 1000 clk with clk_10ms static -> no output change.
